// File: rtl/sr_func_unit_pkg.sv
// Shared constants for the schoolRISCV custom functional unit:
// FSM encodings, iteration count and the custom-instruction opcode fields.
package sr_func_unit_pkg;

  localparam logic [1:0] FU_IDLE = 2'd0;
  localparam logic [1:0] FU_CALC = 2'd1;
  localparam logic [1:0] FU_SUM  = 2'd2;

  localparam int FU_ITERS = 8;

  // Decode fields for the custom-0 instruction issued by the core.
  localparam logic [6:0] FU_OPCODE = 7'b0001011;
  localparam logic [2:0] FU_FUNCT3 = 3'b000;
  localparam logic [6:0] FU_FUNCT7 = 7'b0000000;

endpackage

// File: rtl/sr_func_unit_if.sv
// Core-to-unit bus. Handshake: the core raises start_i for one cycle while busy_o is low;
// the unit owns the operation until busy_o falls, at which point y_bo holds the new result.
interface sr_func_unit_if;
  logic [31:0] a;
  logic [31:0] b;
  logic        start_i;
  logic        busy_o;
  logic [15:0] y_bo;

  modport master (output a, output b, output start_i, input busy_o, input y_bo);
  modport slave  (input a, input b, input start_i, output busy_o, output y_bo);
endinterface

// File: rtl/sr_isqrt_step.sv
// One bit-pair step of the restoring integer square root; purely combinational.
module sr_isqrt_step (
  input  logic [15:0] x,
  input  logic [15:0] res,
  input  logic [15:0] bitVal,
  output logic [15:0] xNext,
  output logic [15:0] resNext
);

  logic [15:0] trial;

  always_comb begin
    trial   = res + bitVal;
    xNext   = x;
    resNext = res >> 1;
    if (x >= trial) begin
      xNext   = x - trial;
      resNext = (res >> 1) + bitVal;
    end
  end

endmodule

// File: rtl/sr_func_unit.sv
// Multi-cycle unit computing y = a[7:0]^2 + floor(sqrt(b[15:0])) in 10 cycles
// (accept, 8 CALC iterations, SUM). Shift-add multiplier inline, sqrt step in a sub-module.
module sr_func_unit
  import sr_func_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  sr_func_unit_if.slave       bus,
  output logic [1:0]          dbgState
);

  logic [1:0]  state;
  logic [2:0]  cnt;
  logic        busy;
  logic [15:0] yReg;

  logic [15:0] ma;
  logic [7:0]  mq;
  logic [15:0] acc;
  logic [15:0] x;
  logic [15:0] res;
  logic [15:0] bitVal;

  logic [15:0] xNext;
  logic [15:0] resNext;

  sr_isqrt_step uStep (
    .x       (x),
    .res     (res),
    .bitVal  (bitVal),
    .xNext   (xNext),
    .resNext (resNext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FU_IDLE;
      cnt    <= 3'd0;
      busy   <= 1'b0;
      yReg   <= 16'd0;
      ma     <= 16'd0;
      mq     <= 8'd0;
      acc    <= 16'd0;
      x      <= 16'd0;
      res    <= 16'd0;
      bitVal <= 16'd0;
    end else begin
      case (state)
        FU_IDLE: begin
          if (bus.start_i) begin
            ma     <= {8'd0, bus.a[7:0]};
            mq     <= bus.a[7:0];
            acc    <= 16'd0;
            x      <= bus.b[15:0];
            res    <= 16'd0;
            bitVal <= 16'h4000;
            cnt    <= 3'd0;
            state  <= FU_CALC;
            busy   <= 1'b1;
          end
        end
        FU_CALC: begin
          if (mq[0]) acc <= acc + ma;
          ma     <= ma << 1;
          mq     <= mq >> 1;
          x      <= xNext;
          res    <= resNext;
          bitVal <= bitVal >> 2;
          cnt    <= cnt + 3'd1;
          if (cnt == 3'(FU_ITERS - 1)) state <= FU_SUM;
        end
        FU_SUM: begin
          // a^2 <= 65025 and sqrt <= 255, so the 16-bit sum cannot wrap.
          yReg  <= acc + {8'd0, res[7:0]};
          state <= FU_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= FU_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o = busy;
  assign bus.y_bo   = yReg;
  assign dbgState   = state;

endmodule
